// File: rtl/alu_execute_stage.sv
// alu_execute_stage: EX pipeline stage behind the ALU control unit.
// Computes the ALU result, zero flag and branch decision. The results sit in an
// EX/MEM register that uses a valid/ready handshake. A one-entry skid buffer
// lets a MEM-stage stall take place without dropping an operation.
// Optional feature macro: ALU_OVF_EN adds the registered out_ovf signed-overflow flag.
module alu_execute_stage #(
    parameter int d_size  = 32,
    parameter int rd_size = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_alu_op,
    input  logic [3:0]         in_alu_opcode,
    input  logic [d_size-1:0]  in_a,
    input  logic [d_size-1:0]  in_b,
    input  logic [rd_size-1:0] in_rd,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [d_size-1:0]  out_result,
    output logic               out_zero,
    output logic               out_branch_taken,
    output logic [1:0]         out_alu_op,
    output logic [rd_size-1:0] out_rd,
`ifdef ALU_OVF_EN
    output logic               out_ovf,
`endif
    output logic               out_illegal
);

    typedef enum logic [3:0] {
        OPC_AND = 4'b0000,
        OPC_OR  = 4'b0001,
        OPC_ADD = 4'b0010,
        OPC_SUB = 4'b0110,
        OPC_SLT = 4'b0111
    } opcode_e;

    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam int         MSB          = d_size - 1;

    // One EX/MEM entry. The flags are computed before capture so they travel with the result.
    typedef struct packed {
        logic [d_size-1:0]  result;
        logic               zero;
        logic               branch_taken;
        logic [1:0]         alu_op;
        logic [rd_size-1:0] rd;
        logic               illegal;
`ifdef ALU_OVF_EN
        logic               ovf;
`endif
    } entry_t;

    logic [d_size-1:0] w_sum;
    logic [d_size-1:0] w_diff;
    logic              w_accept;
    logic              w_transfer;
    entry_t            w_new;

    entry_t            r_main;
    logic              r_main_valid;
    entry_t            r_skid;
    logic              r_skid_valid;

    assign w_sum      = in_a + in_b;
    assign w_diff     = in_a - in_b;
    assign in_ready   = rst & ~r_skid_valid;
    assign w_accept   = in_valid & in_ready;
    assign w_transfer = r_main_valid & out_ready;

    // ALU datapath: build the entry that would be captured from the current inputs.
    always_comb begin
        // NOTE: default every field first so no path through the case can infer a latch.
        w_new         = '0;
        w_new.alu_op  = in_alu_op;
        w_new.rd      = in_rd;
        case (in_alu_opcode)
            OPC_ADD: w_new.result = w_sum;
            OPC_SUB: w_new.result = w_diff;
            OPC_AND: w_new.result = in_a & in_b;
            OPC_OR:  w_new.result = in_a | in_b;
            OPC_SLT: w_new.result = {{(d_size-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            default: w_new.illegal = 1'b1;
        endcase
        w_new.zero         = (w_new.result == '0);
        w_new.branch_taken = (in_alu_op == ALUOP_BRANCH) & w_new.zero;
`ifdef ALU_OVF_EN
        // Add overflows when the operand signs match and the result sign differs.
        // Sub overflows when the operand signs differ and the result sign differs from A.
        if (in_alu_opcode == OPC_ADD) begin
            w_new.ovf = (in_a[MSB] == in_b[MSB]) & (w_sum[MSB] != in_a[MSB]);
        end else if (in_alu_opcode == OPC_SUB) begin
            w_new.ovf = (in_a[MSB] != in_b[MSB]) & (w_diff[MSB] != in_a[MSB]);
        end
`endif
    end

    // Main/skid register pair. Reset and flush empty the stage, and main refills from skid first.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            // NOTE: the payload registers are cleared as well because out_* must read 0 after reset or flush.
            r_main       <= '0;
            r_main_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_transfer) begin
            if (r_skid_valid) begin
                // in_ready is low while skid is full, so no accept can collide with this refill.
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main       <= w_new;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Main is stalled, so park the new operation in skid. in_ready drops next cycle.
            r_skid       <= w_new;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid        = r_main_valid;
    assign out_result       = r_main.result;
    assign out_zero         = r_main.zero;
    assign out_branch_taken = r_main.branch_taken;
    assign out_alu_op       = r_main.alu_op;
    assign out_rd           = r_main.rd;
    assign out_illegal      = r_main.illegal;
`ifdef ALU_OVF_EN
    assign out_ovf          = r_main.ovf;
`endif

endmodule
